// File: rtl/wrap_event_timer.sv
// -----------------------------------------------------------------------------
// wrap_event_timer
//
// Watches the count output of an upstream free-running mod-N counter, counts
// its wraps (N-1 -> 0) and raises a level interrupt when the wrap count reaches
// a programmable match value. It also flags any illegal step of the upstream
// counter.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   count_in    in   [WIDTH-1:0] upstream counter value
//   start       in   pulse: clear wrap_count and arm (enter RUN)
//   stop        in   pulse: disarm (enter IDLE), clear irq
//   match_val   in   [MW-1:0] wrap count that triggers irq; 0 never matches
//   irq_ack     in   pulse: acknowledge a pending irq
//   irq         out  level interrupt, held until acknowledged
//   wrap_count  out  [MW-1:0] wraps since last start or match
//   busy        out  high while armed (RUN or PEND)
//   overrun     out  sticky: match while irq already pending
//   seq_err     out  sticky: count_in broke mod-N sequencing
// -----------------------------------------------------------------------------
module wrap_event_timer #(
    parameter int N     = 10,
    parameter int WIDTH = 4,
    parameter int MW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             start,
    input  logic             stop,
    input  logic [MW-1:0]    match_val,
    input  logic             irq_ack,
    output logic             irq,
    output logic [MW-1:0]    wrap_count,
    output logic             busy,
    output logic             overrun,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [MW-1:0]    W_ONE = MW'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_q_reg;
    logic             valid_q_reg;
    logic [MW-1:0]    wrap_count_reg, wrap_count_next;
    logic             overrun_reg, overrun_next;
    logic             seq_err_reg, seq_err_next;

    logic [WIDTH-1:0] count_succ;
    logic             in_range;
    logic             legal_step;
    logic             wrap;
    logic [MW-1:0]    wrap_inc;
    logic             match;

    // -------------------------------------------------------------------------
    // Upstream counter observation
    // -------------------------------------------------------------------------
    always_comb begin
        count_succ = (count_q_reg == LAST) ? '0 : count_q_reg + C_ONE;
        // Any value >= N is illegal even if it repeats (a stuck-out-of-range
        // counter must not look like a legal hold).
        in_range   = ({1'b0, count_in} < N_EXT);
        legal_step = in_range && ((count_in == count_q_reg) || (count_in == count_succ));
        // valid_q gates both checks so the first sample after reset, which has
        // no meaningful predecessor, is never judged.
        wrap       = valid_q_reg && (count_q_reg == LAST) && (count_in == '0);
        wrap_inc   = wrap_count_reg + W_ONE;
        match      = wrap && (match_val != '0) && (wrap_inc == match_val);
    end

    // -------------------------------------------------------------------------
    // State register (plus datapath registers updated alongside the FSM)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_q_reg    <= '0;
            valid_q_reg    <= 1'b0;
            wrap_count_reg <= '0;
            overrun_reg    <= 1'b0;
            seq_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_q_reg    <= count_in;
            valid_q_reg    <= 1'b1;
            wrap_count_reg <= wrap_count_next;
            overrun_reg    <= overrun_next;
            seq_err_reg    <= seq_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: stop > start > wrap / acknowledge.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        wrap_count_next = wrap_count_reg;
        overrun_next    = overrun_reg;
        seq_err_next    = seq_err_reg | (valid_q_reg & ~legal_step);

        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            state_next      = RUN;
            wrap_count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                RUN: begin
                    if (match) begin
                        state_next      = PEND;
                        wrap_count_next = '0;
                    end else if (wrap) begin
                        wrap_count_next = wrap_inc;
                    end
                end
                PEND: begin
                    if (match) begin
                        // A fresh match wins over a same-cycle ack: the new
                        // event stays pending and is not an overrun.
                        wrap_count_next = '0;
                        if (!irq_ack) begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        if (wrap) begin
                            wrap_count_next = wrap_inc;
                        end
                        if (irq_ack) begin
                            state_next = RUN;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. irq is exactly "in PEND", so any exit from PEND (ack, stop,
    // restart, reset) drops it with no extra bookkeeping.
    // -------------------------------------------------------------------------
    always_comb begin
        irq        = (state_reg == PEND);
        busy       = (state_reg != IDLE);
        wrap_count = wrap_count_reg;
        overrun    = overrun_reg;
        seq_err    = seq_err_reg;
    end

endmodule
